icache_fetch_resp: RTL and testbench

ICACHE_FETCH_RESP -- requirements
Module: icache_fetch_resp

---
 rtl/icache_fetch_resp.sv | 159 +++++++++++++++
 tb/tb_icache_fetch_resp.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_resp.sv
// Direct-mapped instruction cache front end for the fetch stage.
//
// A fetch address is looked up every cycle; a hit returns the stored word
// combinationally with STALL_2IF low. A miss latches the line address, asks
// the backing memory for the line (REQ), writes the returned beats in
// ascending word order (FILL), spends one settle cycle (DONE) and goes back
// to IDLE, where the current fetch address is looked up again.
//
// Ports:
//   CLK, RESET             clock and synchronous active-high reset
//   Instr_address_fIF      fetch address
//   Flush                  invalidate every line
//   Instr1_2IF, STALL_2IF  hit data (0 when not hitting) and fetch freeze
//   Mem_req_valid/addr     line-fill request, handshaked by Mem_req_ready
//   Mem_rvalid, Mem_rdata  fill beats
//   Hit_count, Miss_count  wrapping event counters
module icache_fetch_resp #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr_address_fIF,
  input  logic        Flush,
  output logic [31:0] Instr1_2IF,
  output logic        STALL_2IF,
  output logic        Mem_req_valid,
  output logic [31:0] Mem_req_addr,
  input  logic        Mem_req_ready,
  input  logic        Mem_rvalid,
  input  logic [31:0] Mem_rdata,
  output logic [31:0] Hit_count,
  output logic [31:0] Miss_count
);

  localparam int unsigned WordBits  = $clog2(WORDS);
  localparam int unsigned IndexBits = $clog2(LINES);
  localparam int unsigned IdxLsb    = 2 + WordBits;
  localparam int unsigned TagLsb    = IdxLsb + IndexBits;
  localparam int unsigned TagBits   = 32 - TagLsb;

  typedef enum logic [1:0] {StIdle, StReq, StFill, StDone} state_e;

  state_e               state_q;
  logic [LINES-1:0]     valid_q;
  logic [TagBits-1:0]   tag_q  [LINES];
  logic [31:0]          data_q [LINES][WORDS];
  logic [WordBits-1:0]  beat_q;
  logic                 flushed_q;
  logic                 req_valid_q;
  logic [31:0]          req_addr_q;
  logic [31:0]          hit_cnt_q;
  logic [31:0]          miss_cnt_q;

  logic [WordBits-1:0]  addr_word;
  logic [IndexBits-1:0] addr_idx;
  logic [TagBits-1:0]   addr_tag;
  logic [IndexBits-1:0] fill_idx;
  logic [TagBits-1:0]   fill_tag;
  logic                 beat_last;
  logic                 fill_we;
  logic                 hit;
  logic                 unused_addr_bits;

  assign addr_word = Instr_address_fIF[IdxLsb-1:2];
  assign addr_idx  = Instr_address_fIF[TagLsb-1:IdxLsb];
  assign addr_tag  = Instr_address_fIF[31:TagLsb];

  // The latched request address doubles as the fill target.
  assign fill_idx  = req_addr_q[TagLsb-1:IdxLsb];
  assign fill_tag  = req_addr_q[31:TagLsb];
  assign beat_last = (beat_q == WordBits'(WORDS - 1));
  assign fill_we   = !RESET && (state_q == StFill) && Mem_rvalid;

  // Byte offset and the zeroed low bits of the line address carry no information.
  assign unused_addr_bits = ^{Instr_address_fIF[1:0], req_addr_q[IdxLsb-1:0]};

  assign hit = (state_q == StIdle) && valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag) &&
               !Flush;

  assign Instr1_2IF    = hit ? data_q[addr_idx][addr_word] : 32'h0;
  assign STALL_2IF     = !hit;
  assign Mem_req_valid = req_valid_q;
  assign Mem_req_addr  = req_addr_q;
  assign Hit_count     = hit_cnt_q;
  assign Miss_count    = miss_cnt_q;

  // Data and tag arrays carry no reset; a line is only trusted once its valid bit is set.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      data_q[fill_idx][beat_q] <= Mem_rdata;
      if (beat_last) begin
        tag_q[fill_idx] <= fill_tag;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      beat_q      <= '0;
      flushed_q   <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      if (Flush) begin
        valid_q <= '0;
      end
      unique case (state_q)
        StIdle: begin
          if (hit) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
          end else if (!Flush) begin
            req_addr_q  <= {addr_tag, addr_idx, {IdxLsb{1'b0}}};
            miss_cnt_q  <= miss_cnt_q + 32'd1;
            req_valid_q <= 1'b1;
            flushed_q   <= 1'b0;
            state_q     <= StReq;
          end
        end
        StReq: begin
          if (Flush) begin
            flushed_q <= 1'b1;
          end
          if (Mem_req_ready) begin
            req_valid_q <= 1'b0;
            beat_q      <= '0;
            state_q     <= StFill;
          end
        end
        StFill: begin
          if (Flush) begin
            flushed_q <= 1'b1;
          end
          if (Mem_rvalid) begin
            beat_q <= beat_q + 1'b1;
            if (beat_last) begin
              // A flush at any point of this miss keeps the line invalid.
              if (!Flush && !flushed_q) begin
                valid_q[fill_idx] <= 1'b1;
              end
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fetch_resp.sv
module tb_icache_fetch_resp;

  localparam int unsigned LINES = 16;
  localparam int unsigned WORDS = 4;
  localparam int unsigned LineBytes = WORDS * 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] Instr_address_fIF = 32'h0;
  logic        Flush = 1'b0;
  logic        Mem_req_ready = 1'b0;
  logic        Mem_rvalid = 1'b0;
  logic [31:0] Mem_rdata = 32'h0;
  logic [31:0] Instr1_2IF;
  logic        STALL_2IF;
  logic        Mem_req_valid;
  logic [31:0] Mem_req_addr;
  logic [31:0] Hit_count;
  logic [31:0] Miss_count;

  icache_fetch_resp #(
    .LINES(LINES),
    .WORDS(WORDS)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .Instr_address_fIF(Instr_address_fIF),
    .Flush            (Flush),
    .Instr1_2IF       (Instr1_2IF),
    .STALL_2IF        (STALL_2IF),
    .Mem_req_valid    (Mem_req_valid),
    .Mem_req_addr     (Mem_req_addr),
    .Mem_req_ready    (Mem_req_ready),
    .Mem_rvalid       (Mem_rvalid),
    .Mem_rdata        (Mem_rdata),
    .Hit_count        (Hit_count),
    .Miss_count       (Miss_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_req_q[$];

  // 0: ready/rvalid always high, 1: random handshakes, 2: ready held low
  int          mem_mode = 0;
  bit          req_fire = 1'b0;
  logic [31:0] req_fire_addr = 32'h0;
  bit          fill_active = 1'b0;
  bit          beat_driven = 1'b0;
  int          fill_beat = 0;
  logic [31:0] fill_line = 32'h0;

  // Reference cache: which line tag each index holds, if any.
  bit          m_valid[LINES];
  logic [31:0] m_tag[LINES];
  logic [31:0] m_hits = 32'h0;
  logic [31:0] m_misses = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] line, input int beat);
    if (line == 32'hBFC00000) return 32'h11 * 32'(beat + 1);
    return (line * 32'h9E3779B1) ^ (32'(beat) * 32'h01010101) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_hits   = 32'h0;
    m_misses = 32'h0;
  endtask

  // Monitor: every hit must deliver the next expected word, every accepted
  // request must carry the next expected line address.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (!STALL_2IF) begin
        if (exp_instr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_hit: actual %h required no hit", Instr1_2IF);
        end else begin
          chk("instr", Instr1_2IF, exp_instr_q.pop_front());
        end
      end else begin
        chk("instr_zero_on_stall", Instr1_2IF, 32'h0);
      end
      if (Mem_req_valid) chk("req_valid_implies_stall", {31'h0, STALL_2IF}, 32'h1);
      if (Mem_req_valid && Mem_req_ready) begin
        req_fire      = 1'b1;
        req_fire_addr = Mem_req_addr;
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: actual %h required no request", Mem_req_addr);
        end else begin
          chk("req_addr", Mem_req_addr, exp_req_q.pop_front());
        end
      end
    end
  end

  // Backing memory: answers each accepted request with WORDS beats in order.
  initial begin : mem_driver
    forever begin
      @(posedge CLK);
      if (beat_driven) begin
        fill_beat++;
        if (fill_beat == WORDS) fill_active = 1'b0;
      end
      if (req_fire) begin
        fill_active = 1'b1;
        fill_beat   = 0;
        fill_line   = req_fire_addr;
        req_fire    = 1'b0;
      end
      if (RESET) begin
        fill_active = 1'b0;
        req_fire    = 1'b0;
      end
      #2;
      case (mem_mode)
        0:       Mem_req_ready = 1'b1;
        1:       Mem_req_ready = ($urandom_range(0, 3) != 0);
        default: Mem_req_ready = 1'b0;
      endcase
      beat_driven = fill_active && (mem_mode == 0 || $urandom_range(0, 2) != 0);
      // Stray rvalid outside a fill must be ignored by the cache.
      Mem_rvalid  = beat_driven || (!fill_active && (mem_mode == 0 || $urandom_range(0, 3) == 0));
      Mem_rdata   = beat_driven ? mem_word(fill_line, fill_beat) : $urandom();
    end
  end

  // Present one fetch and hold it until the cache stops stalling. A nonzero
  // flush_cyc pulses Flush on that stall cycle of a miss.
  task automatic fetch(input logic [31:0] a, input int flush_cyc);
    int          idx;
    int          k;
    logic [31:0] tag;
    logic [31:0] line;
    bit          miss;
    bit          flushed;
    line    = a - (a % LineBytes);
    idx     = int'((a / LineBytes) % LINES);
    tag     = a / (LineBytes * LINES);
    miss    = !(m_valid[idx] && m_tag[idx] == tag);
    flushed = miss && flush_cyc > 0;
    if (miss) begin
      exp_req_q.push_back(line);
      m_misses++;
    end
    if (flushed) begin
      exp_req_q.push_back(line);
      m_misses++;
    end
    exp_instr_q.push_back(mem_word(line, int'((a / 4) % WORDS)));
    Instr_address_fIF = a;
    k = 0;
    forever begin
      @(negedge CLK);
      if (!STALL_2IF) break;
      k++;
      if (k > 400) begin
        chk("fetch_timeout", 32'(k), 32'd400);
        finish_run();
      end
      @(posedge CLK);
      #1;
      Flush = (k == flush_cyc);
    end
    m_hits++;
    if (flushed) for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    if (miss) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
    end
    if (mem_mode == 0) chk("stall_cycles", 32'(k), miss ? 32'((flushed ? 2 : 1) * (WORDS + 3)) : 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic flush_idle(input logic [31:0] a);
    Instr_address_fIF = a;
    Flush = 1'b1;
    @(negedge CLK);
    chk("flush_idle_stall", {31'h0, STALL_2IF}, 32'h1);
    @(posedge CLK);
    #1;
    Flush = 1'b0;
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  initial begin : stimulus
    logic [31:0] a;
    int          r;
    model_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("rst_req_valid", {31'h0, Mem_req_valid}, 32'h0);
    chk("rst_req_addr", Mem_req_addr, 32'h0);
    chk("rst_hit_count", Hit_count, 32'h0);
    chk("rst_miss_count", Miss_count, 32'h0);
    chk("rst_stall", {31'h0, STALL_2IF}, 32'h1);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Cold miss, then streaming hits within the line.
    mem_mode = 0;
    fetch(32'hBFC00000, 0);
    chk("miss_count_first", Miss_count, 32'd1);
    fetch(32'hBFC00004, 0);
    fetch(32'hBFC00008, 0);
    fetch(32'hBFC0000C, 0);
    chk("hit_count_line", Hit_count, 32'd4);

    // Conflicting tag on index 0 evicts the line.
    fetch(32'hBFC00100, 0);
    fetch(32'hBFC00000, 0);
    chk("miss_count_conflict", Miss_count, 32'd3);

    // Flush on the second fill beat: the refilled line must not survive.
    fetch(32'hBFC00100, 0);
    fetch(32'hBFC00000, 3);
    fetch(32'hBFC00000, 0);
    chk("miss_count_flush", Miss_count, 32'd6);

    // Request held off by memory, then reset in the middle of the fill.
    mem_mode = 2;
    Instr_address_fIF = 32'hBFC00040;
    exp_req_q.push_back(32'hBFC00040);
    @(negedge CLK);
    chk("hold_idle_req_valid", {31'h0, Mem_req_valid}, 32'h0);
    @(posedge CLK);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("hold_req_valid", {31'h0, Mem_req_valid}, 32'h1);
      chk("hold_req_addr", Mem_req_addr, 32'hBFC00040);
      chk("hold_stall", {31'h0, STALL_2IF}, 32'h1);
      @(posedge CLK);
      #1;
    end
    mem_mode = 0;
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("midfill_rst_req_valid", {31'h0, Mem_req_valid}, 32'h0);
    chk("midfill_rst_hit_count", Hit_count, 32'h0);
    chk("midfill_rst_miss_count", Miss_count, 32'h0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
    fetch(32'hBFC00040, 0);
    fetch(32'hBFC00000, 0);
    chk("miss_count_after_rst", Miss_count, 32'd2);

    // Randomized traffic over a few tags and indices.
    for (int n = 0; n < 250; n++) begin
      a = 32'hBFC00000 + 32'($urandom_range(0, 2)) * 32'h100 + 32'($urandom_range(0, 5)) * 32'h10
          + 32'($urandom_range(0, WORDS - 1)) * 32'h4 + 32'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        flush_idle(a);
      end else if (r == 1) begin
        mem_mode = 0;
        fetch(a, int'($urandom_range(1, WORDS + 2)));
      end else begin
        mem_mode = (r < 4) ? 0 : 1;
        fetch(a, 0);
      end
    end

    chk("final_hit_count", Hit_count, m_hits);
    chk("final_miss_count", Miss_count, m_misses);
    chk("instr_queue_drained", 32'(exp_instr_q.size()), 32'd0);
    chk("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
    finish_run();
  end

  initial begin : watchdog
    #2_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog: actual still running required finished");
    finish_run();
  end

endmodule
